// File: rtl/icache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : icache_ctrl
//  Description : Direct-mapped instruction cache between fetch and the
//                instruction memory port. Hits return the instruction in the
//                same cycle. Misses run a word-serial line fill over a
//                request/valid handshake. Out-of-range PCs and memory errors
//                are reported as instruction access faults.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK          in   1   clock, rising edge
//    RESET        in   1   synchronous active-high reset
//    FE_PC        in  64   fetch PC (bits [1:0] ignored)
//    FE_REQ       in   1   fetch request for FE_PC this cycle
//    FLUSH        in   1   invalidate-all pulse (FENCE.I)
//    ICACHE_R     out  1   ICACHE_INSTR valid for FE_PC this cycle
//    ICACHE_INSTR out 32   instruction word
//    ICACHE_IAF   out  1   access fault, qualified by ICACHE_R
//    MEM_REQ      out  1   memory read request, one word per beat
//    MEM_ADDR     out 64   word-aligned read address
//    MEM_RDATA    in  32   read data
//    MEM_RVALID   in   1   beat complete
//    MEM_ERR      in   1   beat failed, sampled with MEM_RVALID
// ============================================================================
module icache_ctrl #(
    parameter int          LINES      = 16,
    parameter int          WORDS      = 4,
    parameter logic [63:0] ADDR_LIMIT = 64'h0000_0000_0001_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [63:0] FE_PC,
    input  logic        FE_REQ,
    input  logic        FLUSH,
    output logic        ICACHE_R,
    output logic [31:0] ICACHE_INSTR,
    output logic        ICACHE_IAF,
    output logic        MEM_REQ,
    output logic [63:0] MEM_ADDR,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_RVALID,
    input  logic        MEM_ERR
);

    localparam int c_WORD_W   = $clog2(WORDS);
    localparam int c_IDX_W    = $clog2(LINES);
    localparam int c_LINE_LSB = 2 + c_WORD_W;
    localparam int c_TAG_LSB  = c_LINE_LSB + c_IDX_W;
    localparam int c_TAG_W    = 64 - c_TAG_LSB;

    localparam logic [c_WORD_W-1:0] c_LAST = c_WORD_W'(WORDS - 1);
    localparam logic [31:0]         c_NOP  = 32'h0000_0013;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FILL  = 2'd1;
    localparam logic [1:0] c_ST_FAULT = 2'd2;

    logic [1:0]            r_state;
    logic [LINES-1:0]      r_valid;
    logic [c_TAG_W-1:0]    r_tag  [LINES];
    logic [31:0]           r_data [LINES][WORDS];
    logic [63:c_LINE_LSB]  r_line;      // line address being filled
    logic [c_WORD_W-1:0]   r_count;
    logic                  r_abort;
    logic [63:0]           r_mem_addr;

    // PC decode
    logic [c_WORD_W-1:0] w_word;
    logic [c_IDX_W-1:0]  w_idx;
    logic [c_TAG_W-1:0]  w_tag;
    logic [c_IDX_W-1:0]  w_fill_idx;
    logic [c_TAG_W-1:0]  w_fill_tag;
    logic                w_in_range;
    logic                w_hit;
    logic                w_miss;
    logic                w_beat_ok;
    logic                w_unused_off;

    assign w_word       = FE_PC[c_LINE_LSB-1:2];
    assign w_idx        = FE_PC[c_TAG_LSB-1:c_LINE_LSB];
    assign w_tag        = FE_PC[63:c_TAG_LSB];
    assign w_fill_idx   = r_line[c_TAG_LSB-1:c_LINE_LSB];
    assign w_fill_tag   = r_line[63:c_TAG_LSB];
    assign w_unused_off = ^FE_PC[1:0];

    assign w_in_range = (FE_PC < ADDR_LIMIT);
    assign w_hit      = FE_REQ & r_valid[w_idx] & (r_tag[w_idx] == w_tag) & w_in_range;
    assign w_miss     = FE_REQ & w_in_range & ~w_hit;
    assign w_beat_ok  = (r_state == c_ST_FILL) & MEM_RVALID & ~MEM_ERR;

    // Control state, valid bits and memory address
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= c_ST_IDLE;
            r_valid    <= '0;
            r_line     <= '0;
            r_count    <= '0;
            r_abort    <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_miss) begin
                        r_line         <= FE_PC[63:c_LINE_LSB];
                        r_valid[w_idx] <= 1'b0;
                        r_count        <= '0;
                        r_abort        <= 1'b0;
                        r_mem_addr     <= {FE_PC[63:c_LINE_LSB], {c_LINE_LSB{1'b0}}};
                        r_state        <= c_ST_FILL;
                    end
                end
                c_ST_FILL: begin
                    if (FLUSH) begin
                        r_abort <= 1'b1;
                    end
                    if (MEM_RVALID) begin
                        if (MEM_ERR) begin
                            // Remaining beats are dropped; the line stays invalid.
                            r_state <= c_ST_FAULT;
                        end else begin
                            r_count    <= r_count + c_WORD_W'(1);
                            r_mem_addr <= r_mem_addr + 64'd4;
                            if (r_count == c_LAST) begin
                                r_valid[w_fill_idx] <= ~r_abort;
                                r_state             <= c_ST_IDLE;
                            end
                        end
                    end
                end
                c_ST_FAULT: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
            // Placed last so it overrides a same-cycle line validation.
            if (FLUSH) begin
                r_valid <= '0;
            end
        end
    end

    // Tag and data arrays carry no reset; validity is tracked by r_valid.
    always_ff @(posedge CLK) begin
        if (!RESET && w_beat_ok) begin
            r_data[w_fill_idx][r_count] <= MEM_RDATA;
            if (r_count == c_LAST) begin
                r_tag[w_fill_idx] <= w_fill_tag;
            end
        end
    end

    // Fetch response is combinational from FE_PC so hits cost no latency.
    always_comb begin
        ICACHE_R     = 1'b0;
        ICACHE_IAF   = 1'b0;
        ICACHE_INSTR = '0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_hit) begin
                    ICACHE_R     = 1'b1;
                    ICACHE_INSTR = r_data[w_idx][w_word];
                end else if (FE_REQ && !w_in_range) begin
                    ICACHE_R     = 1'b1;
                    ICACHE_IAF   = 1'b1;
                    ICACHE_INSTR = c_NOP;
                end
            end
            c_ST_FAULT: begin
                if (FE_REQ && (FE_PC[63:c_LINE_LSB] == r_line)) begin
                    ICACHE_R     = 1'b1;
                    ICACHE_IAF   = 1'b1;
                    ICACHE_INSTR = c_NOP;
                end
            end
            default: begin
            end
        endcase
    end

    assign MEM_REQ  = (r_state == c_ST_FILL);
    assign MEM_ADDR = r_mem_addr;

endmodule
`default_nettype wire

// File: tb/tb_icache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_ctrl
//  Description : Directed self-checking bench for icache_ctrl. The memory
//                responder answers each presented address one cycle later;
//                word content at byte address a is 0xA0 + (a>>2) - 0x40, so
//                0x100..0x10C read 0xA0..0xA3 and 0x200 reads 0xE0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_ctrl;

    logic        CLK;
    logic        RESET;
    logic [63:0] FE_PC;
    logic        FE_REQ;
    logic        FLUSH;
    logic        ICACHE_R;
    logic [31:0] ICACHE_INSTR;
    logic        ICACHE_IAF;
    logic        MEM_REQ;
    logic [63:0] MEM_ADDR;
    logic [31:0] MEM_RDATA;
    logic        MEM_RVALID;
    logic        MEM_ERR;

    int          total;
    int          bad;

    logic [63:0] err_addr;
    logic [63:0] seen_addr;
    logic        seen_valid;

    icache_ctrl #(
        .LINES      (16),
        .WORDS      (4),
        .ADDR_LIMIT (64'h0000_0000_0001_0000)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .FE_PC        (FE_PC),
        .FE_REQ       (FE_REQ),
        .FLUSH        (FLUSH),
        .ICACHE_R     (ICACHE_R),
        .ICACHE_INSTR (ICACHE_INSTR),
        .ICACHE_IAF   (ICACHE_IAF),
        .MEM_REQ      (MEM_REQ),
        .MEM_ADDR     (MEM_ADDR),
        .MEM_RDATA    (MEM_RDATA),
        .MEM_RVALID   (MEM_RVALID),
        .MEM_ERR      (MEM_ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return 32'h0000_00A0 + 32'(a[31:2]) - 32'h0000_0040;
    endfunction

    // One clock: pass the rising edge, then at the falling edge update the
    // memory responder. A newly presented address is answered next cycle.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
        if (MEM_REQ) begin
            if (seen_valid && (MEM_ADDR == seen_addr) && !MEM_RVALID) begin
                MEM_RVALID = 1'b1;
                MEM_RDATA  = mem_word(MEM_ADDR);
                MEM_ERR    = (MEM_ADDR == err_addr);
            end else begin
                MEM_RVALID = 1'b0;
                MEM_ERR    = 1'b0;
                MEM_RDATA  = '0;
                seen_addr  = MEM_ADDR;
                seen_valid = 1'b1;
            end
        end else begin
            MEM_RVALID = 1'b0;
            MEM_ERR    = 1'b0;
            MEM_RDATA  = '0;
            seen_valid = 1'b0;
        end
        #1;
    endtask

    // Holds the current request until ICACHE_R rises; n = cycles waited, or -1.
    task automatic wait_resp(input int limit, output int n);
        n = 0;
        while (ICACHE_R !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        if (ICACHE_R !== 1'b1) n = -1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        #1;
        total++;
        if (ICACHE_R !== 1'b0 || ICACHE_IAF !== 1'b0 || ICACHE_INSTR !== 32'h0) begin
            bad++;
            $display("FAIL reset_fetch_out: R=%0b IAF=%0b INSTR=%h want 0/0/0", ICACHE_R, ICACHE_IAF, ICACHE_INSTR);
        end
        total++;
        if (MEM_REQ !== 1'b0 || MEM_ADDR !== 64'h0) begin
            bad++;
            $display("FAIL reset_mem_out: REQ=%0b ADDR=%h want 0/0", MEM_REQ, MEM_ADDR);
        end
    endtask

    task automatic test_cold_miss();
        logic [63:0] exp_addr [4];
        int beat;
        int n;
        exp_addr = '{64'h100, 64'h104, 64'h108, 64'h10C};
        FE_PC  = 64'h100;
        FE_REQ = 1'b1;
        #1;
        total++;
        if (ICACHE_R !== 1'b0) begin
            bad++;
            $display("FAIL cold_miss_req_cycle: R=%0b want 0", ICACHE_R);
        end
        beat = 0;
        n    = 0;
        while (ICACHE_R !== 1'b1 && n < 20) begin
            tick();
            n++;
            if (MEM_RVALID === 1'b1) begin
                if (beat < 4) begin
                    total++;
                    if (MEM_ADDR !== exp_addr[beat]) begin
                        bad++;
                        $display("FAIL cold_miss_addr%0d: ADDR=%h want %h", beat, MEM_ADDR, exp_addr[beat]);
                    end
                end
                beat++;
            end
        end
        total++;
        if (beat != 4) begin
            bad++;
            $display("FAIL cold_miss_beats: got %0d want 4", beat);
        end
        // Request cycle plus nine edges: the hit is in the tenth cycle.
        total++;
        if (n != 9) begin
            bad++;
            $display("FAIL cold_miss_latency: edges=%0d want 9", n);
        end
        total++;
        if (ICACHE_R !== 1'b1 || ICACHE_INSTR !== 32'hA0 || ICACHE_IAF !== 1'b0) begin
            bad++;
            $display("FAIL cold_miss_data: R=%0b INSTR=%h IAF=%0b want 1/000000a0/0", ICACHE_R, ICACHE_INSTR, ICACHE_IAF);
        end
    endtask

    task automatic test_hits();
        logic [31:0] exp_w [4];
        exp_w = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        FE_REQ = 1'b1;
        FE_PC  = 64'h108;
        #1;
        total++;
        if (ICACHE_R !== 1'b1 || ICACHE_INSTR !== 32'hA2 || MEM_REQ !== 1'b0) begin
            bad++;
            $display("FAIL hit_108: R=%0b INSTR=%h REQ=%0b want 1/000000a2/0", ICACHE_R, ICACHE_INSTR, MEM_REQ);
        end
        // Back-to-back hits across the line, one per cycle.
        for (int i = 0; i < 4; i++) begin
            FE_PC = 64'h100 + 64'(4 * i);
            #1;
            total++;
            if (ICACHE_R !== 1'b1 || ICACHE_INSTR !== exp_w[i]) begin
                bad++;
                $display("FAIL hit_word%0d: R=%0b INSTR=%h want 1/%h", i, ICACHE_R, ICACHE_INSTR, exp_w[i]);
            end
            tick();
        end
        total++;
        if (MEM_REQ !== 1'b0) begin
            bad++;
            $display("FAIL hit_no_fill: REQ=%0b want 0", MEM_REQ);
        end
        FE_REQ = 1'b0;
    endtask

    task automatic test_conflict();
        int n;
        FE_REQ = 1'b1;
        FE_PC  = 64'h200;
        #1;
        total++;
        if (ICACHE_R !== 1'b0) begin
            bad++;
            $display("FAIL conflict_miss_200: R=%0b want 0", ICACHE_R);
        end
        wait_resp(20, n);
        total++;
        if (n != 9 || ICACHE_INSTR !== 32'hE0) begin
            bad++;
            $display("FAIL conflict_fill_200: edges=%0d INSTR=%h want 9/000000e0", n, ICACHE_INSTR);
        end
        FE_PC = 64'h100;
        #1;
        total++;
        if (ICACHE_R !== 1'b0) begin
            bad++;
            $display("FAIL conflict_evict_100: R=%0b want 0", ICACHE_R);
        end
        wait_resp(20, n);
        total++;
        if (n != 9 || ICACHE_INSTR !== 32'hA0) begin
            bad++;
            $display("FAIL conflict_refill_100: edges=%0d INSTR=%h want 9/000000a0", n, ICACHE_INSTR);
        end
        FE_REQ = 1'b0;
        tick();
    endtask

    task automatic test_mem_error();
        int n;
        err_addr = 64'h308;
        FE_REQ   = 1'b1;
        FE_PC    = 64'h300;
        #1;
        n = 0;
        while (!(MEM_RVALID === 1'b1 && MEM_ERR === 1'b1) && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (n != 6 || MEM_ADDR !== 64'h308) begin
            bad++;
            $display("FAIL err_beat: edges=%0d ADDR=%h want 6/308", n, MEM_ADDR);
        end
        tick();
        total++;
        if (ICACHE_R !== 1'b1 || ICACHE_IAF !== 1'b1 || ICACHE_INSTR !== 32'h13 || MEM_REQ !== 1'b0) begin
            bad++;
            $display("FAIL err_fault_resp: R=%0b IAF=%0b INSTR=%h REQ=%0b want 1/1/00000013/0",
                     ICACHE_R, ICACHE_IAF, ICACHE_INSTR, MEM_REQ);
        end
        tick();
        total++;
        if (ICACHE_R !== 1'b0) begin
            bad++;
            $display("FAIL err_line_invalid: R=%0b want 0", ICACHE_R);
        end
        FE_REQ   = 1'b0;
        err_addr = '1;
        tick();
    endtask

    task automatic test_out_of_range();
        FE_REQ = 1'b1;
        FE_PC  = 64'h0000_0000_0001_0000;
        #1;
        total++;
        if (ICACHE_R !== 1'b1 || ICACHE_IAF !== 1'b1 || ICACHE_INSTR !== 32'h13) begin
            bad++;
            $display("FAIL oor_resp: R=%0b IAF=%0b INSTR=%h want 1/1/00000013", ICACHE_R, ICACHE_IAF, ICACHE_INSTR);
        end
        tick();
        total++;
        if (MEM_REQ !== 1'b0) begin
            bad++;
            $display("FAIL oor_no_fill: REQ=%0b want 0", MEM_REQ);
        end
        // Last in-range word is an ordinary miss.
        FE_PC = 64'h0000_0000_0000_FFFC;
        #1;
        total++;
        if (ICACHE_R !== 1'b0 || ICACHE_IAF !== 1'b0) begin
            bad++;
            $display("FAIL oor_edge_inrange: R=%0b IAF=%0b want 0/0", ICACHE_R, ICACHE_IAF);
        end
        FE_REQ = 1'b0;
        tick();
    endtask

    task automatic test_flush_mid_fill();
        int beats;
        int n;
        FLUSH = 1'b1;
        tick();
        FLUSH  = 1'b0;
        FE_REQ = 1'b1;
        FE_PC  = 64'h100;
        #1;
        total++;
        if (ICACHE_R !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle_invalidates: R=%0b want 0", ICACHE_R);
        end
        tick();
        // A new PC during the fill must not redirect it.
        FE_PC = 64'h500;
        beats = 0;
        n     = 0;
        while (MEM_REQ === 1'b1 && n < 30) begin
            if (n == 2) FLUSH = 1'b1;
            else        FLUSH = 1'b0;
            tick();
            n++;
            if (MEM_RVALID === 1'b1) begin
                beats++;
                if (beats == 4) begin
                    total++;
                    if (MEM_ADDR !== 64'h10C) begin
                        bad++;
                        $display("FAIL flush_last_addr: ADDR=%h want 10c", MEM_ADDR);
                    end
                end
            end
        end
        FLUSH = 1'b0;
        total++;
        if (beats != 4) begin
            bad++;
            $display("FAIL flush_drain_beats: got %0d want 4", beats);
        end
        FE_PC = 64'h100;
        #1;
        total++;
        if (ICACHE_R !== 1'b0) begin
            bad++;
            $display("FAIL flush_line_invalid: R=%0b want 0", ICACHE_R);
        end
        FE_REQ = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_fill();
        FE_REQ = 1'b1;
        FE_PC  = 64'h100;
        #1;
        tick();
        FE_REQ = 1'b0;
        tick();
        tick();
        total++;
        if (MEM_REQ !== 1'b1) begin
            bad++;
            $display("FAIL rst_fill_active: REQ=%0b want 1", MEM_REQ);
        end
        RESET = 1'b1;
        tick();
        total++;
        if (MEM_REQ !== 1'b0 || MEM_ADDR !== 64'h0) begin
            bad++;
            $display("FAIL rst_abandon: REQ=%0b ADDR=%h want 0/0", MEM_REQ, MEM_ADDR);
        end
        RESET  = 1'b0;
        FE_REQ = 1'b1;
        FE_PC  = 64'h100;
        #1;
        total++;
        if (ICACHE_R !== 1'b0) begin
            bad++;
            $display("FAIL rst_line_invalid: R=%0b want 0", ICACHE_R);
        end
        FE_REQ = 1'b0;
        tick();
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        RESET      = 1'b1;
        FE_PC      = '0;
        FE_REQ     = 1'b0;
        FLUSH      = 1'b0;
        MEM_RDATA  = '0;
        MEM_RVALID = 1'b0;
        MEM_ERR    = 1'b0;
        err_addr   = '1;
        seen_addr  = '0;
        seen_valid = 1'b0;

        test_reset();
        test_cold_miss();
        test_hits();
        test_conflict();
        test_mem_error();
        test_out_of_range();
        test_flush_mid_fill();
        test_reset_mid_fill();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/icache_ctrl.md
# icache_ctrl

Direct-mapped instruction cache that answers the fetch stage's PC lookups and refills missing lines from instruction memory over a word-serial request/valid handshake. It sits between fetch and the instruction memory port. On a hit it returns the instruction in the same cycle. On a miss it runs a line-fill state machine. It reports instruction access faults for out-of-range addresses and memory errors, which fetch forwards as F_IAF.

## Interface
- LINES, 16: number of cache lines; power of two, ≥2.
- WORDS, 4: 32-bit words per line; power of two, ≥2.
- ADDR_LIMIT, 64'h0000_0000_0001_0000: first byte address outside instruction memory.

- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- FE_PC  in  64  fetch PC; bits [1:0] ignored.
- FE_REQ  in  1  fetch requests an instruction at FE_PC this cycle.
- FLUSH  in  1  FENCE.I invalidate-all pulse.
- ICACHE_R  out  1  ICACHE_INSTR valid for FE_PC this cycle.
- ICACHE_INSTR  out  32  instruction word.
- ICACHE_IAF  out  1  access fault for FE_PC; qualified by ICACHE_R.
- MEM_REQ  out  1  memory read request, one word per beat.
- MEM_ADDR  out  64  word-aligned read address.
- MEM_RDATA  in  32  read data.
- MEM_RVALID  in  1  beat complete; MEM_RDATA valid.
- MEM_ERR  in  1  beat failed; sampled with MEM_RVALID.

## Operation
- Address split: off = PC[1:0]; word = next log2(WORDS) bits; idx = next log2(LINES) bits; tag = remaining upper bits. Tag width = 62 − log2(WORDS) − log2(LINES).
- Storage: flop arrays valid[LINES], tag[LINES], data[LINES][WORDS], read asynchronously.
- hit = FE_REQ & valid[idx] & tag[idx]==tag(FE_PC) & FE_PC < ADDR_LIMIT.
- States:
  - IDLE
    - hit: ICACHE_R=1, ICACHE_INSTR = data[idx][word], ICACHE_IAF=0.
    - FE_REQ & FE_PC ≥ ADDR_LIMIT: ICACHE_R=1, ICACHE_IAF=1, ICACHE_INSTR=32'h0000_0013 (NOP). No fill.
    - FE_REQ & miss: latch line base = FE_PC with word and off bits cleared. Clear valid[idx]. Set beat count=0, abort=0. Go to FILL.
  - FILL
    - MEM_REQ=1; MEM_ADDR = base + 4·count, held stable until a beat completes.
    - On MEM_RVALID & !MEM_ERR: write data[idx][count]; count++.
    - On the last beat (count == WORDS−1): write tag[idx]; set valid[idx] = !abort. Go to IDLE.
    - On MEM_RVALID & MEM_ERR: drop the remainder of the line; leave valid[idx]=0. Go to FAULT.
    - ICACHE_R=0 throughout FILL.
  - FAULT: one cycle. If FE_REQ and FE_PC's line equals base: ICACHE_R=1, ICACHE_IAF=1, ICACHE_INSTR=NOP. Then go to IDLE, irrespective of FE_REQ.
- FLUSH: clears all valid bits next edge. If it arrives during FILL, set abort; the fill drains its remaining beats but the line is not validated. FLUSH has priority over a same-cycle validate.
- FE_PC changes during FILL: the fill completes for the latched base. The new PC is looked up in IDLE.
- MEM_RVALID outside FILL is ignored.
- Reset values: FSM=IDLE, all valid=0, count=0, abort=0, MEM_REQ=0, MEM_ADDR=0, ICACHE_R=0, ICACHE_IAF=0, ICACHE_INSTR=0. Tag and data arrays are not reset.
- RESET during FILL abandons the fill immediately: MEM_REQ=0 the next cycle, and the line stays invalid.

## Timing
- Hit latency 0: ICACHE_R is combinational from FE_PC in IDLE.
- Miss penalty: 1 cycle (IDLE→FILL), then one beat per word, plus 1 cycle to return to IDLE, where the refetch hits.
- With memory returning MEM_RVALID on the cycle after each address presentation: miss to hit = 2·WORDS + 2 cycles. For WORDS=4 that is 10 cycles.
- MEM_ADDR advances on the edge following each completed beat.
- Fault response is visible exactly one cycle after the failing beat.

## Test plan
- Cold miss: RESET, then FE_REQ with FE_PC=0x100, memory returns 0xA0,0xA1,0xA2,0xA3 one beat per cycle -> MEM_ADDR sequence 0x100,0x104,0x108,0x10C; ICACHE_R=1 with INSTR=0xA0 10 cycles after the request.
- Hits: after the fill, FE_PC=0x108 -> ICACHE_R=1, INSTR=0xA2 same cycle, MEM_REQ=0.
- Conflict: fill 0x100, then FE_PC=0x100+LINES·WORDS·4=0x200 -> miss and refill of index 0; a subsequent access to 0x100 misses again.
- Memory error: MEM_ERR on beat 2 of a fill for 0x300 -> next cycle ICACHE_R=1, ICACHE_IAF=1, INSTR=0x13; a re-access to 0x300 misses again.
- Out of range: FE_PC=ADDR_LIMIT -> same-cycle ICACHE_IAF=1, ICACHE_R=1, MEM_REQ stays 0.
- FLUSH mid-fill, and RESET mid-fill -> line 0x100 not valid afterwards. For FLUSH, all remaining beats are consumed. For RESET, MEM_REQ=0 one cycle after RESET.
